// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// load states and frame geometry.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } loadState_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HEADER_BYTES   = 4;
    localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/imem_boot_loader_boot_byte_packer.sv
// Big-endian byte-to-word assembler shared by the header count and payload words;
// wordValid fires combinationally on the handshake that supplies the last byte.
module boot_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 byteEn,
    input  logic [7:0]           byteIn,
    output logic [WORD_BITS-1:0] word,
    output logic                 wordValid
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [WORD_BITS-9:0] shiftReg;
    logic [IDX_W-1:0]     byteIdx;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shiftReg <= '0;
            byteIdx  <= '0;
        end else if (byteEn) begin
            shiftReg <= {shiftReg[WORD_BITS-17:0], byteIn};
            byteIdx  <= byteIdx + IDX_W'(1);
        end
    end

    assign word      = {shiftReg, byteIn};
    assign wordValid = byteEn && (byteIdx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a checksummed program image into instruction memory and holds the
// core in reset until the whole image has been written and verified.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH  = 32,
    parameter int                       INSTR_WIDTH    = 32,
    parameter int                       MEM_DEPTH      = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                       TIMEOUT_CYCLES = 65535
)(
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_Valid,
    input  logic [7:0]               i_Byte,
    output logic                     o_Ready,
    output logic                     o_WE,
    output logic [ADDRESS_WIDTH-1:0] o_Addr,
    output logic [INSTR_WIDTH-1:0]   o_WData,
    output logic                     o_CoreRstN,
    output logic                     o_Done,
    output logic                     o_Error
);

    localparam int HDR_BITS  = 8 * HEADER_BYTES;
    localparam int CNT_W     = $clog2(MEM_DEPTH + 1);
    localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

    loadState_t           state;
    logic [CNT_W-1:0]     wordCnt;
    logic [CNT_W-1:0]     wordTarget;
    logic [7:0]           xorAcc;
    logic [TO_W-1:0]      idleCnt;
    logic                 started;

    logic                 handshake;
    logic                 packEn;
    logic [WORD_BITS-1:0] packedWord;
    logic                 wordValid;
    logic [HDR_BITS-1:0]  hdrCount;

    assign o_Ready   = (state == HDR) || (state == DATA) || (state == CSUM);
    assign handshake = i_Valid && o_Ready;
    assign packEn    = handshake && ((state == HDR) || (state == DATA));
    assign hdrCount  = packedWord;

    boot_byte_packer u_packer (
        .clk       (i_CLK),
        .rstN      (i_RST),
        .byteEn    (packEn),
        .byteIn    (i_Byte),
        .word      (packedWord),
        .wordValid (wordValid)
    );

    // NOTE: reset clears only loader state; instruction memory keeps what was written.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state      <= HDR;
            wordCnt    <= '0;
            wordTarget <= '0;
            xorAcc     <= '0;
            idleCnt    <= '0;
            started    <= 1'b0;
            o_WE       <= 1'b0;
            o_Addr     <= BASE_ADDR;
            o_WData    <= '0;
            o_CoreRstN <= 1'b0;
            o_Done     <= 1'b0;
            o_Error    <= 1'b0;
        end else begin
            // NOTE: o_WE defaults low every cycle so it can only ever be a one-cycle pulse.
            o_WE <= 1'b0;

            if (handshake) begin
                started <= 1'b1;
                idleCnt <= '0;
                xorAcc  <= xorAcc ^ i_Byte;
            end else if (started && o_Ready && (TIMEOUT_CYCLES != 0)) begin
                if (idleCnt == TO_LAST) begin
                    state   <= ERR;
                    o_Error <= 1'b1;
                end else begin
                    idleCnt <= idleCnt + TO_W'(1);
                end
            end

            case (state)
                HDR: begin
                    if (wordValid) begin
                        if (hdrCount > HDR_BITS'(MEM_DEPTH)) begin
                            state   <= ERR;
                            o_Error <= 1'b1;
                        end else if (hdrCount == '0) begin
                            state <= CSUM;
                        end else begin
                            state      <= DATA;
                            wordTarget <= CNT_W'(hdrCount);
                        end
                    end
                end
                DATA: begin
                    if (wordValid) begin
                        o_WE    <= 1'b1;
                        o_WData <= packedWord;
                        o_Addr  <= BASE_ADDR + (ADDRESS_WIDTH'(wordCnt) << 2);
                        wordCnt <= wordCnt + CNT_W'(1);
                        if (wordCnt + CNT_W'(1) == wordTarget) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (handshake) begin
                        if (i_Byte == xorAcc) begin
                            state      <= DONE;
                            o_Done     <= 1'b1;
                            o_CoreRstN <= 1'b1;
                        end else begin
                            state   <= ERR;
                            o_Error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad images, header limits,
// idle timeout and mid-load reset, all with hand-computed expectations.
module tb_imem_boot_loader;

    localparam int AW      = 32;
    localparam int IW      = 32;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 8;

    logic          i_CLK   = 1'b0;
    logic          i_RST   = 1'b0;
    logic          i_Valid = 1'b0;
    logic [7:0]    i_Byte  = 8'h00;
    logic          o_Ready;
    logic          o_WE;
    logic [AW-1:0] o_Addr;
    logic [IW-1:0] o_WData;
    logic          o_CoreRstN;
    logic          o_Done;
    logic          o_Error;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] wAddrQ[$];
    logic [31:0] wDataQ[$];

    imem_boot_loader #(
        .ADDRESS_WIDTH  (AW),
        .INSTR_WIDTH    (IW),
        .MEM_DEPTH      (DEPTH),
        .BASE_ADDR      ('0),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_Valid    (i_Valid),
        .i_Byte     (i_Byte),
        .o_Ready    (o_Ready),
        .o_WE       (o_WE),
        .o_Addr     (o_Addr),
        .o_WData    (o_WData),
        .o_CoreRstN (o_CoreRstN),
        .o_Done     (o_Done),
        .o_Error    (o_Error)
    );

    always #5 i_CLK = ~i_CLK;

    // Write pulses are captured mid-cycle, away from the active edge.
    always @(negedge i_CLK) begin
        if (o_WE === 1'b1) begin
            wAddrQ.push_back(o_Addr);
            wDataQ.push_back(o_WData);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic doReset();
        @(negedge i_CLK);
        i_RST   = 1'b0;
        i_Valid = 1'b0;
        wAddrQ.delete();
        wDataQ.delete();
        repeat (2) @(negedge i_CLK);
        i_RST = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge i_CLK);
            i_Valid = 1'b0;
        end
        @(negedge i_CLK);
        i_Valid = 1'b1;
        i_Byte  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_CLK);
            i_Valid = 1'b0;
        end
    endtask

    // N=2 image {0x20080005, 0x2009000A}; correct checksum is 0x0C.
    task automatic sendImage(input logic [7:0] csumXor, input int gapMax);
        logic [7:0] frame [0:12];
        int gap;
        frame = '{8'h00, 8'h00, 8'h00, 8'h02,
                  8'h20, 8'h08, 8'h00, 8'h05,
                  8'h20, 8'h09, 8'h00, 8'h0A,
                  8'h0C};
        frame[12] = frame[12] ^ csumXor;
        for (int i = 0; i < 13; i++) begin
            gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            sendByte(frame[i], gap);
            if (gapMax == 0 && i == 12) begin
                check("lastWriteWE",   o_WE,    32'd1);
                check("lastWriteAddr", o_Addr,  32'h4);
                check("lastWriteData", o_WData, 32'h2009000A);
                check("csumReady",     o_Ready, 32'd1);
                check("doneBeforeCsum", o_Done, 32'd0);
            end
        end
        idle(1);
    endtask

    task automatic checkTwoWrites(input string tag);
        check({tag, "Count"}, wAddrQ.size(), 32'd2);
        if (wAddrQ.size() >= 2) begin
            check({tag, "Addr0"}, wAddrQ[0], 32'h0);
            check({tag, "Data0"}, wDataQ[0], 32'h20080005);
            check({tag, "Addr1"}, wAddrQ[1], 32'h4);
            check({tag, "Data1"}, wDataQ[1], 32'h2009000A);
        end
    endtask

    initial begin
        // Reset values
        @(negedge i_CLK);
        check("rstWE",      o_WE,       32'd0);
        check("rstAddr",    o_Addr,     32'h0);
        check("rstWData",   o_WData,    32'h0);
        check("rstCoreRst", o_CoreRstN, 32'd0);
        check("rstDone",    o_Done,     32'd0);
        check("rstError",   o_Error,    32'd0);
        i_RST = 1'b1;
        @(negedge i_CLK);
        check("rstReady",   o_Ready,    32'd1);

        // Good image, valid held high
        sendImage(8'h00, 0);
        checkTwoWrites("good");
        check("goodDone",    o_Done,     32'd1);
        check("goodCoreRst", o_CoreRstN, 32'd1);
        check("goodReady",   o_Ready,    32'd0);
        check("goodError",   o_Error,    32'd0);
        sendByte(8'hFF, 0);
        sendByte(8'hEE, 0);
        idle(2);
        check("doneIgnoreWrites", wAddrQ.size(), 32'd2);
        check("doneSticky",       o_Done,        32'd1);

        // Bad checksum
        doReset();
        sendImage(8'h01, 0);
        checkTwoWrites("badCsum");
        check("badCsumError",   o_Error,    32'd1);
        check("badCsumCoreRst", o_CoreRstN, 32'd0);
        check("badCsumDone",    o_Done,     32'd0);
        check("badCsumReady",   o_Ready,    32'd0);

        // Header N = MEM_DEPTH + 1
        doReset();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h01, 0);
        sendByte(8'h01, 0);
        idle(1);
        check("bigNError",   o_Error,    32'd1);
        check("bigNReady",   o_Ready,    32'd0);
        check("bigNCoreRst", o_CoreRstN, 32'd0);
        for (int i = 0; i < 4; i++) sendByte(8'h20 + 8'(i), 0);
        idle(2);
        check("bigNWrites",  wAddrQ.size(), 32'd0);

        // Header N = 0, correct checksum
        doReset();
        for (int i = 0; i < 4; i++) sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        idle(1);
        check("zeroNDone",    o_Done,        32'd1);
        check("zeroNCoreRst", o_CoreRstN,    32'd1);
        check("zeroNWrites",  wAddrQ.size(), 32'd0);

        // Header N = 0, wrong checksum
        doReset();
        for (int i = 0; i < 4; i++) sendByte(8'h00, 0);
        sendByte(8'h5A, 0);
        idle(1);
        check("zeroNBadError", o_Error, 32'd1);
        check("zeroNBadDone",  o_Done,  32'd0);

        // Random gaps of at most TIMEOUT-1 idle cycles
        doReset();
        sendImage(8'h00, TIMEOUT - 1);
        checkTwoWrites("gaps");
        check("gapsDone",  o_Done,  32'd1);
        check("gapsError", o_Error, 32'd0);

        // Idle gap mid-word: 7 cycles survive, the 8th fires the timeout
        doReset();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'h20, 0);
        sendByte(8'h08, 0);
        idle(TIMEOUT);
        check("timeoutGap7",    o_Error, 32'd0);
        idle(1);
        check("timeoutGap8",    o_Error,       32'd1);
        check("timeoutCoreRst", o_CoreRstN,    32'd0);
        check("timeoutWrites",  wAddrQ.size(), 32'd0);

        // Asynchronous reset after 5 payload bytes, then a full reload
        doReset();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'h20, 0);
        sendByte(8'h08, 0);
        sendByte(8'h00, 0);
        sendByte(8'h05, 0);
        sendByte(8'h20, 0);
        idle(1);
        check("preResetWrites", wAddrQ.size(), 32'd1);
        check("preResetWData",  o_WData,       32'h20080005);
        #2;
        i_RST = 1'b0;
        #1;
        check("asyncRstWData",   o_WData,    32'h0);
        check("asyncRstAddr",    o_Addr,     32'h0);
        check("asyncRstWE",      o_WE,       32'd0);
        check("asyncRstCoreRst", o_CoreRstN, 32'd0);
        check("asyncRstReady",   o_Ready,    32'd1);
        @(negedge i_CLK);
        wAddrQ.delete();
        wDataQ.delete();
        i_RST = 1'b1;
        sendImage(8'h00, 0);
        checkTwoWrites("reload");
        check("reloadDone", o_Done, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits directly upstream of the pipelined MIPS core.
- Receives a program image as a byte stream (valid/ready), assembles big-endian 32-bit instruction words and writes them into instruction memory through a single-cycle write port.
- Holds the core in reset until the image is fully loaded and its checksum verifies; then releases the core, which starts fetching at BASE_ADDR.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width of the instruction memory write port
- INSTR_WIDTH, 32, instruction word width (fixed at 4 bytes)
- MEM_DEPTH, 256, instruction memory capacity in words
- BASE_ADDR, 0, byte address of the first loaded word
- TIMEOUT_CYCLES, 65535, maximum idle cycles between bytes once loading has begun (0 disables)

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  asynchronous active-low reset
- i_Valid  in  1  byte on i_Byte is valid
- i_Byte  in  8  stream byte
- o_Ready  out  1  loader accepts a byte this cycle
- o_WE  out  1  instruction memory write enable, one-cycle pulse
- o_Addr  out  ADDRESS_WIDTH  write byte address
- o_WData  out  INSTR_WIDTH  write data
- o_CoreRstN  out  1  active-low reset to the core
- o_Done  out  1  image loaded and verified (sticky)
- o_Error  out  1  load failed (sticky)

Behaviour:
- Reset (i_RST=0, asynchronous): state HDR; byte counter, word counter, XOR accumulator and timeout counter = 0; o_WE=0, o_Addr=BASE_ADDR, o_WData=0, o_CoreRstN=0, o_Done=0, o_Error=0.
- Byte transfer: occurs when i_Valid && o_Ready. o_Ready=1 in HDR, DATA and CSUM; 0 in DONE and ERR.
- Frame format: 4-byte word count N (MSB first), then N words of 4 bytes each (MSB first), then 1 checksum byte.
- Checksum: XOR of all header and payload bytes.
- State HDR:
  - Shift in 4 bytes.
  - On the 4th byte: N > MEM_DEPTH -> ERR; N == 0 -> CSUM; otherwise -> DATA.
- State DATA:
  - Shift bytes into the word register.
  - On each 4th byte, the next cycle drives o_WE=1, o_WData=the assembled word and o_Addr=BASE_ADDR+4*index.
  - Latency is 1 cycle from the 4th-byte handshake to the write pulse.
  - The address increments by 4 after each write. Back-to-back bytes are accepted with no bubble.
  - After word N is accepted -> CSUM. The final write pulse coincides with the first CSUM cycle.
- State CSUM:
  - On one byte: match against the accumulator -> DONE, otherwise -> ERR.
- State DONE:
  - The cycle after the checksum handshake, o_Done=1 and o_CoreRstN=1.
  - Both stay high until i_RST. Further bytes are ignored (o_Ready=0).
- State ERR:
  - o_Error=1 and o_CoreRstN=0 until i_RST. No further writes.
- Timeout:
  - The counter runs only after the first byte has been accepted, and only in HDR, DATA or CSUM.
  - It clears on every handshake.
  - Reaching TIMEOUT_CYCLES -> ERR. With TIMEOUT_CYCLES=0 the timeout never fires.
- Widths:
  - The word counter is wide enough for MEM_DEPTH.
  - The address wraps modulo 2^ADDRESS_WIDTH. This cannot occur for legal N.
- Reset mid-load: all state is discarded, the core is held in reset, and already-written memory is not cleared.
- o_WE never asserts outside DATA or the first CSUM cycle.

Decomposition:
- Shared package holds:
  - state encoding HDR/DATA/CSUM/DONE/ERR
  - BYTES_PER_WORD=4
  - the header length constant
- One sub-module is natural: boot_byte_packer. It is a 4-byte big-endian shift/assembly register with a byte index counter and a word_valid pulse, and is used for both the header and payload words.
- The FSM, counters, checksum and timeout live in the top level.

Test Plan:
- Image N=2, words 0x20080005, 0x2009000A, correct checksum, i_Valid held high:
  - o_WE pulses twice, at addr 0x0 then 0x4, with the exact words.
  - o_Done=1 and o_CoreRstN=1 one cycle after the checksum byte.
  - o_Ready=0 afterward.
- Same image with checksum XOR 0x01:
  - Both writes occur.
  - o_Error=1, o_CoreRstN stays 0, o_Done=0.
- Header N=MEM_DEPTH+1 (0x00000101 at depth 256):
  - ERR immediately after the 4th header byte.
  - No o_WE pulse.
- Header N=0 followed by checksum 0x00:
  - DONE with no writes.
  - A wrong checksum byte gives ERR instead.
- Random i_Valid gaps below TIMEOUT_CYCLES (set to 8) succeed.
- A gap of 8 idle cycles mid-word forces ERR.
- i_RST asserted after 5 payload bytes, then a full valid image:
  - Outputs return to reset values asynchronously.
  - The second load completes with addresses restarting at BASE_ADDR.
